// File: rtl/parity_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : parity_mem_reader
// Purpose  : Read-side front end for a parity-protected word array. Accepts
//            one valid/ready read request at a time, strobes the array for a
//            single cycle, checks the returned data against the stored parity
//            bit one cycle later, and presents data plus an error flag on a
//            valid/ready response port. A saturating error counter and a
//            sticky error flag record every parity mismatch seen.
// Ports    : clk, rst_n               - clock, synchronous active-low reset
//            req_valid/req_ready/
//            req_addr                 - read request handshake and address
//            mem_rd_en/mem_addr       - one-cycle read strobe and address
//            mem_rdata/mem_rparity    - array word and stored parity bit,
//                                       valid the cycle after mem_rd_en
//            resp_valid/resp_ready/
//            resp_data/resp_err       - response handshake, data, mismatch
//            err_count/err_sticky     - saturating and sticky error status
//            err_clr                  - synchronous clear of error status
// Revision : 1.0  initial release
// ============================================================================
module parity_mem_reader #(
  parameter int WORD_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter bit PARITY_ODD = 1'b0,
  parameter int ERR_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rparity,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = ERR_CNT_W'(1);

  state_t r_state;

  // Parity recomputed from the returned word; odd mode inverts the sense.
  logic w_exp_parity;
  logic w_par_err;

  assign w_exp_parity = (^mem_rdata) ^ PARITY_ODD;
  assign w_par_err    = (w_exp_parity != mem_rparity);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      req_ready  <= 1'b1;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            // The address register doubles as the latched request address.
            mem_addr  <= req_addr;
            mem_rd_en <= 1'b1;
            req_ready <= 1'b0;
            r_state   <= READ;
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          r_state   <= CHECK;
        end
        CHECK: begin
          resp_data  <= mem_rdata;
          resp_err   <= w_par_err;
          resp_valid <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A clear coincident with a new mismatch is applied first, so the new
      // event still counts and leaves the counter at one.
      if ((r_state == CHECK) && w_par_err) begin
        err_sticky <= 1'b1;
        if (err_clr) begin
          err_count <= C_CNT_ONE;
        end else if (err_count != C_CNT_MAX) begin
          err_count <= err_count + C_CNT_ONE;
        end
      end else if (err_clr) begin
        err_count  <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_mem_reader
// Purpose  : Self-checking bench for parity_mem_reader. Two instances share
//            all request/response stimulus: one in even-parity mode and one
//            in odd-parity mode, each served by its own copy of a small
//            registered array model. A transaction-level reference model
//            predicts every output cycle by cycle; directed literal values
//            pin the model on the hand-computed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_parity_mem_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid;
  logic [1:0] req_addr;
  logic resp_ready;
  logic err_clr;

  logic [1:0]       req_ready_w, rd_en_w, resp_valid_w, resp_err_w, sticky_w;
  logic [1:0][1:0]  mem_addr_w;
  logic [1:0][3:0]  resp_data_w, err_count_w, rdata_w;
  logic [1:0]       rparity_w;

  // Array contents (data word and stored parity bit), shared by both instances.
  logic [3:0] mem_d [4];
  logic       mem_p [4];

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  parity_mem_reader #(.WORD_WIDTH(4), .ADDR_WIDTH(2), .PARITY_ODD(1'b0), .ERR_CNT_W(4)) dut_even (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_addr(req_addr),
    .mem_rd_en(rd_en_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_rdata(rdata_w[0]), .mem_rparity(rparity_w[0]),
    .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready),
    .resp_data(resp_data_w[0]), .resp_err(resp_err_w[0]),
    .err_count(err_count_w[0]), .err_sticky(sticky_w[0]), .err_clr(err_clr)
  );

  parity_mem_reader #(.WORD_WIDTH(4), .ADDR_WIDTH(2), .PARITY_ODD(1'b1), .ERR_CNT_W(4)) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_addr(req_addr),
    .mem_rd_en(rd_en_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_rdata(rdata_w[1]), .mem_rparity(rparity_w[1]),
    .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready),
    .resp_data(resp_data_w[1]), .resp_err(resp_err_w[1]),
    .err_count(err_count_w[1]), .err_sticky(sticky_w[1]), .err_clr(err_clr)
  );

  // Array model: one-cycle read latency per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en_w[k]) begin
        rdata_w[k]   <= mem_d[mem_addr_w[k]];
        rparity_w[k] <= mem_p[mem_addr_w[k]];
      end
    end
  end

  // Reference model: age counts edges since the request was accepted.
  bit       m_busy   [2];
  int       m_age    [2];
  logic [1:0] m_addr [2];
  logic [3:0] m_data [2];
  bit       m_err    [2];
  int       m_cnt    [2];
  bit       m_sticky [2];

  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_age[k] = 0; m_cnt[k] = 0; m_sticky[k] = 0;
      end else begin
        bit ev;
        ev = 0;
        if (!m_busy[k]) begin
          if (req_valid) begin
            m_busy[k] = 1; m_age[k] = 1; m_addr[k] = req_addr;
          end
        end else if (m_age[k] == 1) begin
          m_age[k] = 2;
        end else if (m_age[k] == 2) begin
          m_age[k]  = 3;
          m_data[k] = mem_d[m_addr[k]];
          m_err[k]  = (((^m_data[k]) ^ k[0]) != mem_p[m_addr[k]]);
          ev        = m_err[k];
        end else if (resp_ready) begin
          m_busy[k] = 0;
        end
        if (err_clr) begin
          m_cnt[k] = 0; m_sticky[k] = 0;
        end
        if (ev) begin
          m_cnt[k]    = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
          m_sticky[k] = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[inst%0d] at %0t: actual=%0d required=%0d", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit e_rd, e_rv;
        e_rd = m_busy[k] && (m_age[k] == 1);
        e_rv = m_busy[k] && (m_age[k] >= 3);
        chk("req_ready", k, int'(req_ready_w[k]), int'(!m_busy[k]));
        chk("mem_rd_en", k, int'(rd_en_w[k]), int'(e_rd));
        if (e_rd) chk("mem_addr", k, int'(mem_addr_w[k]), int'(m_addr[k]));
        chk("resp_valid", k, int'(resp_valid_w[k]), int'(e_rv));
        if (e_rv) begin
          chk("resp_data", k, int'(resp_data_w[k]), int'(m_data[k]));
          chk("resp_err", k, int'(resp_err_w[k]), int'(m_err[k]));
        end
        chk("err_count", k, int'(err_count_w[k]), m_cnt[k]);
        chk("err_sticky", k, int'(sticky_w[k]), int'(m_sticky[k]));
      end
    end
  end

  // Values captured during the most recent transaction.
  logic       last_rden;
  logic [1:0] last_maddr;
  logic [3:0] last_data [2];
  logic       last_err  [2];
  logic [3:0] last_cnt  [2];
  logic       last_sticky [2];

  // Must be called at a negedge; returns at the negedge of the first idle cycle.
  task automatic read_txn(input logic [1:0] a, input int bp, input bit clr_in_check);
    req_valid = 1'b1; req_addr = a; resp_ready = (bp == 0);
    @(negedge clk);                       // READ cycle
    last_rden  = rd_en_w[0];
    last_maddr = mem_addr_w[0];
    req_valid  = (bp > 0);                // ignored while busy
    req_addr   = 2'd0;
    @(negedge clk);                       // CHECK cycle
    if (clr_in_check) err_clr = 1'b1;
    @(negedge clk);                       // first RESP cycle
    err_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      last_data[k] = resp_data_w[k]; last_err[k] = resp_err_w[k];
      last_cnt[k]  = err_count_w[k]; last_sticky[k] = sticky_w[k];
    end
    repeat (bp) @(negedge clk);
    if (bp > 0) begin
      chk("bp_req_ready", 0, int'(req_ready_w[0]), 0);
      chk("bp_resp_valid", 0, int'(resp_valid_w[0]), 1);
      chk("bp_resp_data_stable", 0, int'(resp_data_w[0]), int'(last_data[0]));
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    if (bp > 0) chk("bp_complete", 0, int'(resp_valid_w[0]), 0);
  endtask

  initial begin
    mem_d[0] = 4'b0000; mem_p[0] = 1'b0;
    mem_d[1] = 4'b0110; mem_p[1] = 1'b1;   // injected flip in even mode
    mem_d[2] = 4'b1011; mem_p[2] = 1'b1;   // clean in even mode
    mem_d[3] = 4'b1111; mem_p[3] = 1'b0;
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 2'd3; resp_ready = 1'b1; err_clr = 1'b0;

    // Reset held with a pending request.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", k, int'(req_ready_w[k]), 1);
      chk("rst_mem_rd_en", k, int'(rd_en_w[k]), 0);
      chk("rst_mem_addr", k, int'(mem_addr_w[k]), 0);
      chk("rst_resp_valid", k, int'(resp_valid_w[k]), 0);
      chk("rst_resp_data", k, int'(resp_data_w[k]), 0);
      chk("rst_resp_err", k, int'(resp_err_w[k]), 0);
      chk("rst_err_count", k, int'(err_count_w[k]), 0);
      chk("rst_err_sticky", k, int'(sticky_w[k]), 0);
    end
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Clean read of address 2.
    read_txn(2'd2, 0, 1'b0);
    chk("clean_rd_en", 0, int'(last_rden), 1);
    chk("clean_addr", 0, int'(last_maddr), 2);
    chk("clean_data", 0, int'(last_data[0]), 11);
    chk("clean_err", 0, int'(last_err[0]), 0);
    chk("clean_cnt", 0, int'(last_cnt[0]), 0);
    chk("clean_odd_err", 1, int'(last_err[1]), 1);

    // Flipped word at address 1; odd mode sees it as clean.
    read_txn(2'd1, 0, 1'b0);
    chk("flip_err", 0, int'(last_err[0]), 1);
    chk("flip_cnt", 0, int'(last_cnt[0]), 1);
    chk("flip_sticky", 0, int'(last_sticky[0]), 1);
    chk("flip_data", 0, int'(last_data[0]), 6);
    chk("flip_odd_err", 1, int'(last_err[1]), 0);

    // Backpressure for five cycles on address 3.
    read_txn(2'd3, 5, 1'b0);
    chk("bp_data", 0, int'(last_data[0]), 15);
    chk("bp_err", 0, int'(last_err[0]), 0);
    chk("bp_odd_cnt", 1, int'(last_cnt[1]), 2);

    // Seventeen more errors saturate the even counter.
    for (int i = 0; i < 17; i++) read_txn(2'd1, 0, 1'b0);
    chk("sat_cnt", 0, int'(err_count_w[0]), 15);
    chk("sat_sticky", 0, int'(sticky_w[0]), 1);

    // Clear coincident with an error: the new error still counts.
    read_txn(2'd1, 0, 1'b1);
    chk("clr_coinc_cnt", 0, int'(last_cnt[0]), 1);
    chk("clr_coinc_sticky", 0, int'(last_sticky[0]), 1);
    chk("clr_coinc_odd_cnt", 1, int'(last_cnt[1]), 0);

    // Clear alone.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_cnt", 0, int'(err_count_w[0]), 0);
    chk("clr_sticky", 0, int'(sticky_w[0]), 0);

    // Build up a nonzero count, then reset during CHECK of an erroneous read.
    read_txn(2'd1, 0, 1'b0);
    req_valid = 1'b1; req_addr = 2'd1;
    @(negedge clk);                       // READ
    req_valid = 1'b0;
    @(negedge clk);                       // CHECK
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_resp_valid", 0, int'(resp_valid_w[0]), 0);
    @(negedge clk);
    chk("midrst_req_ready", 0, int'(req_ready_w[0]), 1);
    chk("midrst_resp_valid2", 0, int'(resp_valid_w[0]), 0);
    chk("midrst_cnt", 0, int'(err_count_w[0]), 0);
    chk("midrst_sticky", 0, int'(sticky_w[0]), 0);

    // A normal read still works afterwards.
    read_txn(2'd0, 0, 1'b0);
    chk("post_data", 0, int'(last_data[0]), 0);
    chk("post_err", 0, int'(last_err[0]), 0);
    chk("post_odd_err", 1, int'(last_err[1]), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
